// File: rtl/mode_router.sv
// Mode router: debounces a mode button and NUM_SW user switches, steps the active mode,
// returns to mode 0 after an idle timeout, and routes switch pulses and the LCD character.

module mode_router_deb #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_pulse
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_lvl;
    logic             r_lvl_q;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_lvl   <= 1'b0;
            r_lvl_q <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // the counter holds how many consecutive samples disagreed with the accepted level
            if (r_sync2 == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_lvl <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_lvl_q <= r_lvl;
            r_pulse <= r_lvl & ~r_lvl_q;
        end
    end

    assign o_pulse = r_pulse;
endmodule

module mode_router #(
    parameter int NUM_MODES   = 4,
    parameter int NUM_SW      = 4,
    parameter int CHAR_W      = 8,
    parameter int DEB_CYCLES  = 500000,
    parameter int TIMEOUT_SEC = 30
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_1hz,
    input  logic                          mode_btn,
    input  logic [NUM_SW-1:0]             sw_raw,
    input  logic                          mode_lock,
    input  logic [NUM_MODES*CHAR_W-1:0]   data_in,
    output logic [NUM_MODES*NUM_SW-1:0]   sw_out,
    output logic [CHAR_W-1:0]             data_char,
    output logic [$clog2(NUM_MODES)-1:0]  mode,
    output logic                          mode_change
);
    localparam int MODE_W = $clog2(NUM_MODES);
    localparam int IDLE_W = (TIMEOUT_SEC < 1) ? 1 : $clog2(TIMEOUT_SEC + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_SEC);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

    logic                        w_btn_pulse;
    logic [NUM_SW-1:0]           w_sw_pulse;
    logic                        w_adv;
    logic                        w_tmo;
    logic                        w_upd;
    logic                        w_activity;
    logic [MODE_W-1:0]           w_mode_nxt;
    logic [IDLE_W-1:0]           w_idle_nxt;
    logic [NUM_MODES*NUM_SW-1:0] w_sw_route;
    logic [CHAR_W-1:0]           w_char_sel;

    logic [MODE_W-1:0]           r_mode;
    logic [IDLE_W-1:0]           r_idle;
    logic                        r_mode_change;
    logic [NUM_MODES*NUM_SW-1:0] r_sw_out;
    logic [CHAR_W-1:0]           r_data_char;

    mode_router_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_btn (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (mode_btn),
        .o_pulse (w_btn_pulse)
    );

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw_deb
        mode_router_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sw (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (sw_raw[gi]),
            .o_pulse (w_sw_pulse[gi])
        );
    end

    always_comb begin
        w_adv      = w_btn_pulse & ~mode_lock;
        w_tmo      = (TIMEOUT_SEC != 0) && (r_idle == IDLE_MAX) && (r_mode != '0) && !mode_lock;
        w_upd      = w_adv | w_tmo;
        w_mode_nxt = r_mode;
        // a button press wins over a simultaneous timeout and counts from the current mode
        if (w_adv) begin
            w_mode_nxt = (r_mode == MODE_LAST) ? '0 : r_mode + 1'b1;
        end else if (w_tmo) begin
            w_mode_nxt = '0;
        end

        w_sw_route = '0;
        w_char_sel = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (r_mode == MODE_W'(m)) begin
                w_sw_route[m*NUM_SW +: NUM_SW] = w_sw_pulse;
                w_char_sel                     = data_in[m*CHAR_W +: CHAR_W];
            end
        end
        if (w_upd) begin
            w_sw_route = '0;
        end

        w_activity = w_btn_pulse | (|w_sw_pulse) | w_upd;
        w_idle_nxt = r_idle;
        if (w_activity) begin
            w_idle_nxt = '0;
        end else if (en_1hz && (r_idle != IDLE_MAX)) begin
            w_idle_nxt = r_idle + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode        <= '0;
            r_idle        <= '0;
            r_mode_change <= 1'b0;
            r_sw_out      <= '0;
            r_data_char   <= '0;
        end else begin
            r_mode        <= w_mode_nxt;
            r_idle        <= w_idle_nxt;
            r_mode_change <= w_upd;
            r_sw_out      <= w_sw_route;
            r_data_char   <= w_char_sel;
        end
    end

    assign sw_out      = r_sw_out;
    assign data_char   = r_data_char;
    assign mode        = r_mode;
    assign mode_change = r_mode_change;
endmodule

// File: tb/tb_mode_router.sv
// Bench for mode_router: directed scenarios plus randomized traffic against a reference model.

module tb_mode_router;
    localparam int N   = 4;
    localparam int NSW = 4;
    localparam int CW  = 8;
    localparam int DEB = 4;
    localparam int TO  = 3;
    localparam int NI  = NSW + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en_1hz = 1'b0;
    logic              mode_btn = 1'b0;
    logic [NSW-1:0]    sw_raw = '0;
    logic              mode_lock = 1'b0;
    logic [N*CW-1:0]   data_in = 32'h44332211;
    logic [N*NSW-1:0]  sw_out;
    logic [CW-1:0]     data_char;
    logic [1:0]        mode;
    logic              mode_change;

    int n_tests = 0;
    int n_fail  = 0;

    mode_router #(
        .NUM_MODES   (N),
        .NUM_SW      (NSW),
        .CHAR_W      (CW),
        .DEB_CYCLES  (DEB),
        .TIMEOUT_SEC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_1hz      (en_1hz),
        .mode_btn    (mode_btn),
        .sw_raw      (sw_raw),
        .mode_lock   (mode_lock),
        .data_in     (data_in),
        .sw_out      (sw_out),
        .data_char   (data_char),
        .mode        (mode),
        .mode_change (mode_change)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: a level is accepted after DEB consecutive disagreeing samples,
    // its rising edge becomes a pulse two edges later, and mode/idle follow plain arithmetic
    bit              m_s1[NI], m_s2[NI], m_lvl[NI], m_rose[NI], m_pulse[NI];
    int              m_run[NI];
    int              m_mode = 0;
    int              m_idle = 0;
    logic [N*NSW-1:0] exp_sw = '0;
    logic            exp_chg = 1'b0;
    logic [CW-1:0]   exp_char = '0;

    always @(posedge clk) begin : ref_model
        bit raw[NI];
        bit adv, tmo, upd, act;
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_rose[i] = 0; m_pulse[i] = 0; m_run[i] = 0;
            end
            m_mode = 0; m_idle = 0; exp_sw = '0; exp_chg = 1'b0; exp_char = '0;
        end else begin
            raw[0] = mode_btn;
            for (int i = 0; i < NSW; i++) raw[i+1] = sw_raw[i];
            adv = m_pulse[0] && !mode_lock;
            tmo = (TO != 0) && (m_idle == TO) && (m_mode != 0) && !mode_lock;
            upd = adv || tmo;
            act = upd || m_pulse[0];
            exp_sw = '0;
            for (int i = 0; i < NSW; i++) begin
                if (m_pulse[i+1]) begin
                    act = 1;
                    if (!upd) exp_sw[m_mode*NSW + i] = 1'b1;
                end
            end
            exp_chg  = upd;
            exp_char = data_in[m_mode*CW +: CW];
            if (act) m_idle = 0;
            else if (en_1hz && m_idle < TO) m_idle = m_idle + 1;
            if (adv) m_mode = (m_mode + 1) % N;
            else if (tmo) m_mode = 0;
            for (int i = 0; i < NI; i++) begin
                m_pulse[i] = m_rose[i];
                m_rose[i]  = 0;
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB) begin
                        m_lvl[i]  = m_s2[i];
                        m_run[i]  = 0;
                        m_rose[i] = m_lvl[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
        end
    end

    always @(negedge clk) begin
        check_eq("model_mode", mode, m_mode);
        check_eq("model_mode_change", mode_change, exp_chg);
        check_eq("model_sw_out", sw_out, exp_sw);
        check_eq("model_data_char", data_char, exp_char);
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic run(input int n, output int chg, output int swp);
        chg = 0;
        swp = 0;
        repeat (n) begin
            step();
            if (mode_change) chg++;
            if (sw_out != 0) swp++;
        end
    endtask

    task automatic press(output int chg);
        int c1, s1, c2, s2;
        mode_btn = 1'b1;
        run(10, c1, s1);
        mode_btn = 1'b0;
        run(10, c2, s2);
        chg = c1 + c2;
    endtask

    task automatic strobe(output int chg);
        int c1, s1, c2, s2;
        en_1hz = 1'b1;
        run(1, c1, s1);
        en_1hz = 1'b0;
        run(4, c2, s2);
        chg = c1 + c2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        int first, cnt, c, s, c2, s2, total, h9, oth;
        int seq[5];
        seq = '{1, 2, 3, 0, 1};

        repeat (2) step();
        check_eq("rst_mode", mode, 0);
        check_eq("rst_mode_change", mode_change, 0);
        check_eq("rst_sw_out", sw_out, 0);
        check_eq("rst_data_char", data_char, 0);
        rst = 1'b1;
        step();

        // first press: latency, single mode_change, character follows one clock later
        mode_btn = 1'b1;
        first = -1;
        cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (mode_change) begin
                cnt++;
                if (first < 0) begin
                    first = n - 1;
                    check_eq("t1_char_old", data_char, 8'h11);
                end
            end
            if (first >= 0 && n == first + 2) check_eq("t1_char_new", data_char, 8'h22);
        end
        check_eq("t1_latency", first, 7);
        check_eq("t1_nchg", cnt, 1);
        check_eq("t1_mode", mode, 1);
        mode_btn = 1'b0;
        run(12, c, s);

        // five presses with wrap
        do_reset();
        total = 0;
        for (int k = 0; k < 5; k++) begin
            press(c);
            total += c;
            check_eq("t2_mode", mode, seq[k]);
        end
        check_eq("t2_nchg", total, 5);

        // switch routing at mode 2 and glitch rejection
        press(c);
        check_eq("t3_mode", mode, 2);
        h9 = 0;
        oth = 0;
        sw_raw[1] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (n == 10) sw_raw[1] = 1'b0;
            step();
            if (sw_out[9]) h9++;
            if ((sw_out & ~16'h0200) != 0) oth++;
        end
        check_eq("t3_bit9_pulses", h9, 1);
        check_eq("t3_other_bits", oth, 0);
        sw_raw[0] = 1'b1;
        run(3, c, s);
        sw_raw[0] = 1'b0;
        run(12, c2, s2);
        check_eq("t3_glitch", s + s2, 0);

        // idle timeout, then the same under lock
        do_reset();
        press(c);
        check_eq("t4_mode1", mode, 1);
        total = 0;
        for (int k = 0; k < 3; k++) begin
            strobe(c);
            total += c;
        end
        run(4, c, s);
        total += c;
        check_eq("t4_timeout_mode", mode, 0);
        check_eq("t4_timeout_nchg", total, 1);
        press(c);
        mode_lock = 1'b1;
        total = 0;
        for (int k = 0; k < 4; k++) begin
            strobe(c);
            total += c;
        end
        check_eq("t4_lock_mode", mode, 1);
        check_eq("t4_lock_nchg", total, 0);
        press(c);
        check_eq("t4_lock_btn_nchg", c, 0);
        check_eq("t4_lock_btn_mode", mode, 1);
        mode_lock = 1'b0;

        // button and switch on the same clock: switch pulse dropped
        do_reset();
        mode_btn  = 1'b1;
        sw_raw[3] = 1'b1;
        run(10, c, s);
        mode_btn  = 1'b0;
        sw_raw[3] = 1'b0;
        run(10, c2, s2);
        check_eq("t5_mode", mode, 1);
        check_eq("t5_nchg", c + c2, 1);
        check_eq("t5_sw_dropped", s + s2, 0);

        // button pulse lands on the same clock the idle count reaches the timeout, at mode 3
        press(c);
        press(c);
        check_eq("t5_mode3", mode, 3);
        strobe(c);
        strobe(c2);
        check_eq("t5_no_early_tmo", c + c2, 0);
        mode_btn = 1'b1;
        run(6, c, s);
        en_1hz = 1'b1;
        run(1, c2, s2);
        total = c + c2;
        en_1hz = 1'b0;
        run(1, c, s);
        check_eq("t5_coincide_chg_edge", c, 1);
        total += c;
        run(12, c, s);
        total += c;
        mode_btn = 1'b0;
        run(12, c, s);
        total += c;
        check_eq("t5_coincide_mode", mode, 0);
        check_eq("t5_coincide_nchg", total, 1);

        // reset mid-debounce at mode 3
        press(c);
        press(c);
        press(c);
        check_eq("t6_mode3", mode, 3);
        mode_btn = 1'b1;
        run(5, c, s);
        rst = 1'b0;
        #1;
        check_eq("t6_rst_mode", mode, 0);
        check_eq("t6_rst_chg", mode_change, 0);
        check_eq("t6_rst_sw", sw_out, 0);
        check_eq("t6_rst_char", data_char, 0);
        step();
        rst = 1'b1;
        first = -1;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (mode_change && first < 0) first = n - 1;
        end
        check_eq("t6_latency", first, 7);
        check_eq("t6_mode", mode, 1);
        mode_btn = 1'b0;
        run(12, c, s);

        // randomized traffic, checked every cycle by the reference model
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(5) == 0) mode_btn = ~mode_btn;
            for (int i = 0; i < NSW; i++) begin
                if ($urandom_range(7) == 0) sw_raw[i] = ~sw_raw[i];
            end
            if ($urandom_range(59) == 0) mode_lock = ~mode_lock;
            en_1hz = ($urandom_range(9) == 0);
            if ($urandom_range(99) == 0) data_in = $urandom;
            rst = ($urandom_range(499) != 0);
            step();
        end
        rst = 1'b1;
        en_1hz = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
